phy_rx_deframer: RTL

Receive-side counterpart of the transmit path. Samples the 4-bit PHY receive nibble stream and packs it into bytes. Buffers each frame in an internal circular byte store and validates its length. Each good frame is then replayed as a byte stream with a 24-bit control block on its first byte: the same f_data / f_ctrl / frame-valid format that xmitTop consumes, so received frames can be looped straight into the transmit path.

---
 rtl/phy_rx_deframer.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/phy_rx_deframer.sv
// phy_rx_deframer
//   Packs the 4-bit PHY receive stream (low nibble first) into bytes, buffers
//   each frame in a circular byte store, checks its length and replays every
//   good frame as f_data / f_ctrl / frame-valid, one byte per clock, with the
//   control block {len,len} on the first byte.
//
// Ports
//   clk_phy        PHY nibble clock (only clock)
//   reset          asynchronous, active-low reset
//   phy_rx_data    receive nibble
//   phy_rx_dv      receive data valid, high for the whole frame
//   f_data_out     replayed frame byte
//   f_data_valid   f_data_out valid
//   f_ctrl_out     {len[11:0], len[11:0]} on the first byte, else 0
//   f_frame_valid  one-cycle pulse on the first byte of a frame
//   rx_discard     one-cycle pulse when a received frame is dropped
//
// DEPTH and LQ_DEPTH must be powers of two (LQ_DEPTH >= 2).
module phy_rx_deframer #(
  parameter int DEPTH    = 4096,
  parameter int MIN_LEN  = 64,
  parameter int MAX_LEN  = 2048,
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic [3:0]  phy_rx_data,
  input  logic        phy_rx_dv,
  output logic [7:0]  f_data_out,
  output logic        f_data_valid,
  output logic [23:0] f_ctrl_out,
  output logic        f_frame_valid,
  output logic        rx_discard
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int LW     = 12;
  localparam int LQW    = $clog2(LQ_DEPTH);
  localparam int LQCW   = $clog2(LQ_DEPTH + 1);
  localparam int STAGES = 1;   // store read stage, then output register

  typedef enum logic [1:0] {R_IDLE, R_LO, R_HI, R_DROP} rx_state_t;
  typedef enum logic [1:0] {D_IDLE, D_DATA, D_GAP}      dr_state_t;

  // ---------------------------------------------------------------------------
  // Shared state
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data;
  logic [PW-1:0] wr_ptr, rd_ptr, commit_ptr, start_ptr;

  logic [LW-1:0]   lq_mem [LQ_DEPTH];
  logic [LQW-1:0]  lq_wp, lq_rp;
  logic [LQCW-1:0] lq_cnt;
  logic [LW-1:0]   lq_head;
  logic            lq_full, lq_empty;

  assign lq_head  = lq_mem[lq_rp];
  assign lq_full  = (lq_cnt == LQCW'(LQ_DEPTH));
  assign lq_empty = (lq_cnt == '0);

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t   rx_state, rx_next;
  logic [LW-1:0] rx_cnt;
  logic [3:0]  lo_nib;
  logic        armed;      // low only for the first cycle after reset release
  logic        store_full, len_ok;
  logic        wr_en, rewind, commit, discard_nxt, frame_start, cap_lo;

  // Same slot index, opposite lap: writer is a whole store ahead of the reader.
  assign store_full = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign len_ok     = (rx_cnt >= LW'(MIN_LEN)) && (rx_cnt <= LW'(MAX_LEN));

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    wr_en       = 1'b0;
    rewind      = 1'b0;
    commit      = 1'b0;
    discard_nxt = 1'b0;
    frame_start = 1'b0;
    cap_lo      = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (phy_rx_dv) begin
          // dv already high when reset released: mid-frame, drop it silently
          if (!armed) rx_next = R_DROP;
          else begin
            frame_start = 1'b1;
            cap_lo      = 1'b1;
            rx_next     = R_HI;
          end
        end
      end
      R_HI: begin
        if (phy_rx_dv) begin
          if (store_full || rx_cnt == LW'(MAX_LEN)) begin
            rewind      = 1'b1;
            discard_nxt = 1'b1;
            rx_next     = R_DROP;
          end else begin
            wr_en   = 1'b1;
            rx_next = R_LO;
          end
        end else begin
          // odd nibble count
          rewind      = 1'b1;
          discard_nxt = 1'b1;
          rx_next     = R_IDLE;
        end
      end
      R_LO: begin
        if (phy_rx_dv) begin
          cap_lo  = 1'b1;
          rx_next = R_HI;
        end else begin
          if (len_ok && !lq_full) commit = 1'b1;
          else begin
            rewind      = 1'b1;
            discard_nxt = 1'b1;
          end
          rx_next = R_IDLE;
        end
      end
      R_DROP: begin
        if (!phy_rx_dv) rx_next = R_IDLE;
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      start_ptr  <= '0;
      commit_ptr <= '0;
      rx_cnt     <= '0;
      lo_nib     <= '0;
      armed      <= 1'b0;
      rx_discard <= 1'b0;
    end else begin
      armed      <= 1'b1;
      rx_discard <= discard_nxt;
      if (cap_lo) lo_nib <= phy_rx_data;
      if (frame_start) begin
        start_ptr <= wr_ptr;
        rx_cnt    <= '0;
      end else if (wr_en) begin
        rx_cnt <= rx_cnt + LW'(1);
      end
      if (rewind)     wr_ptr <= start_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (commit) commit_ptr <= wr_ptr;
    end
  end

  // ---------------------------------------------------------------------------
  // Length queue: pushed on commit, popped by the drain FSM
  // ---------------------------------------------------------------------------
  logic lq_pop;

  always_ff @(posedge clk_phy) begin
    if (commit) lq_mem[lq_wp] <= rx_cnt;
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      lq_wp  <= '0;
      lq_rp  <= '0;
      lq_cnt <= '0;
    end else begin
      if (commit) lq_wp <= lq_wp + LQW'(1);
      if (lq_pop) lq_rp <= lq_rp + LQW'(1);
      case ({commit, lq_pop})
        2'b10:   lq_cnt <= lq_cnt + LQCW'(1);
        2'b01:   lq_cnt <= lq_cnt - LQCW'(1);
        default: lq_cnt <= lq_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Byte store: write port from receive, registered read port for drain.
  // The writer never targets the slot being read: that would need store_full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_phy) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {phy_rx_data, lo_nib};
    rd_data <= mem[rd_ptr[AW-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  dr_state_t     d_state, d_next;
  logic [LW-1:0] d_cnt;       // bytes still to read after the current one
  logic          rd_issue, rd_avail;
  logic [STAGES:0] vld_pipe;
  logic          first_s1;
  logic [LW-1:0] len_s1;

  // Guard only; a queued length always has its bytes committed.
  assign rd_avail = (rd_ptr != commit_ptr);

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) d_state <= D_IDLE;
    else        d_state <= d_next;
  end

  always_comb begin
    d_next   = d_state;
    lq_pop   = 1'b0;
    rd_issue = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (!lq_empty && rd_avail) begin
          lq_pop   = 1'b1;
          rd_issue = 1'b1;
          d_next   = (lq_head > LW'(1)) ? D_DATA : D_GAP;
        end
      end
      D_DATA: begin
        if (rd_avail) begin
          rd_issue = 1'b1;
          if (d_cnt == LW'(1)) d_next = D_GAP;
        end
      end
      D_GAP:   d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      rd_ptr        <= '0;
      d_cnt         <= '0;
      vld_pipe      <= '0;
      first_s1      <= 1'b0;
      len_s1        <= '0;
      f_data_out    <= '0;
      f_ctrl_out    <= '0;
      f_frame_valid <= 1'b0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
      if (lq_pop)        d_cnt <= lq_head - LW'(1);
      else if (rd_issue) d_cnt <= d_cnt - LW'(1);
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
      first_s1 <= lq_pop;
      if (lq_pop) len_s1 <= lq_head;
      f_data_out    <= vld_pipe[STAGES-1] ? rd_data : 8'h00;
      f_frame_valid <= first_s1;
      f_ctrl_out    <= first_s1 ? {len_s1, len_s1} : 24'h0;
    end
  end

  assign f_data_valid = vld_pipe[STAGES];

endmodule
